// File: rtl/regfile_writer.sv
// 32 x 32-bit register file with byte-enabled writes, one-cycle write
// acknowledge and a saturating count of writes that changed storage.

// One storage register: per-byte load when selected, async clear.
module regfile_writer_lane #(
    parameter int VEC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic [VEC_W/8-1:0] bsel,
    input  logic [VEC_W-1:0]   din,
    output logic [VEC_W-1:0]   q
);
    // byte lanes load independently; unselected bytes hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (sel) begin
            for (int b = 0; b < VEC_W/8; b++) begin
                if (bsel[b]) q[b*8 +: 8] <= din[b*8 +: 8];
            end
        end
    end
endmodule

module regfile_writer #(
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      din,
    input  logic [4:0]       awr,
    input  logic             wren,
    input  logic [3:0]       bsel,
    output logic [31:0]      dout0,
    output logic [31:0]      dout1,
    output logic [31:0]      dout2,
    output logic [31:0]      dout3,
    output logic [31:0]      dout4,
    output logic [31:0]      dout5,
    output logic [31:0]      dout6,
    output logic [31:0]      dout7,
    output logic [31:0]      dout8,
    output logic [31:0]      dout9,
    output logic [31:0]      dout10,
    output logic [31:0]      dout11,
    output logic [31:0]      dout12,
    output logic [31:0]      dout13,
    output logic [31:0]      dout14,
    output logic [31:0]      dout15,
    output logic [31:0]      dout16,
    output logic [31:0]      dout17,
    output logic [31:0]      dout18,
    output logic [31:0]      dout19,
    output logic [31:0]      dout20,
    output logic [31:0]      dout21,
    output logic [31:0]      dout22,
    output logic [31:0]      dout23,
    output logic [31:0]      dout24,
    output logic [31:0]      dout25,
    output logic [31:0]      dout26,
    output logic [31:0]      dout27,
    output logic [31:0]      dout28,
    output logic [31:0]      dout29,
    output logic [31:0]      dout30,
    output logic [31:0]      dout31,
    output logic             wrack,
    output logic [CNT_W-1:0] wrcnt
);
    localparam int NUM_LANES = 32;
    localparam int VEC_W     = 32;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_LANES-1:0][VEC_W-1:0] rq;
    logic                            commit;

    // each lane decodes its own address slot; together they form the one-hot decoder
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        if (ZERO_REG && i == 0) begin : g_zero
            assign rq[i] = '0;
        end else begin : g_reg
            regfile_writer_lane #(.VEC_W(VEC_W)) u_lane (
                .clk  (clk),
                .rst_n(rst_n),
                .sel  (wren && (awr == 5'(i))),
                .bsel (bsel),
                .din  (din),
                .q    (rq[i])
            );
        end
    end

    // a write counts only if it can actually change a register
    assign commit = wren && (bsel != 4'b0000) && !(ZERO_REG && awr == 5'd0);

    // acknowledge every sampled request, committed or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrack <= 1'b0;
        else        wrack <= wren;
    end

    // saturating commit counter; holds at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        wrcnt <= '0;
        else if (commit && wrcnt != '1)    wrcnt <= wrcnt + CNT_ONE;
    end

    assign dout0  = rq[0];
    assign dout1  = rq[1];
    assign dout2  = rq[2];
    assign dout3  = rq[3];
    assign dout4  = rq[4];
    assign dout5  = rq[5];
    assign dout6  = rq[6];
    assign dout7  = rq[7];
    assign dout8  = rq[8];
    assign dout9  = rq[9];
    assign dout10 = rq[10];
    assign dout11 = rq[11];
    assign dout12 = rq[12];
    assign dout13 = rq[13];
    assign dout14 = rq[14];
    assign dout15 = rq[15];
    assign dout16 = rq[16];
    assign dout17 = rq[17];
    assign dout18 = rq[18];
    assign dout19 = rq[19];
    assign dout20 = rq[20];
    assign dout21 = rq[21];
    assign dout22 = rq[22];
    assign dout23 = rq[23];
    assign dout24 = rq[24];
    assign dout25 = rq[25];
    assign dout26 = rq[26];
    assign dout27 = rq[27];
    assign dout28 = rq[28];
    assign dout29 = rq[29];
    assign dout30 = rq[30];
    assign dout31 = rq[31];
endmodule
